// File: rtl/tff_counter_seq_pkg.sv
// -----------------------------------------------------------------------------
// tff_counter_seq_pkg
// Shared types and constants for the T-flip-flop counter sequencer.
//   seq_state_e    : sequencer FSM state encoding (visible on the state port)
//   MODE_FREE      : counter wraps to 0 at the terminal count forever
//   MODE_ONESHOT   : counter stops at the terminal count and reports done
//   state_is_busy  : true while a count run is active or paused
// -----------------------------------------------------------------------------
package tff_counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    function automatic logic state_is_busy(input seq_state_e s);
        return (s == RUN) || (s == PAUSE);
    endfunction

endpackage

// File: rtl/tff_counter_core.sv
// -----------------------------------------------------------------------------
// tff_counter_core
// Synchronous binary up-counter built from one T flip-flop per bit.
// Bit i toggles when en is high and every lower bit is 1; sclr clears all bits
// and wins over en.
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   en     in   count enable (one increment per enabled edge)
//   sclr   in   synchronous clear, priority over en
//   count  out  current counter value
// -----------------------------------------------------------------------------
module tff_counter_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sclr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] w_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_tff
        logic r_t;
        logic w_lower_ones;

        // Toggle condition of a synchronous binary counter: all lower bits set.
        if (i == 0) begin : g_lsb
            assign w_lower_ones = 1'b1;
        end else begin : g_upper
            assign w_lower_ones = &w_q[i-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_t <= 1'b0;
            end else if (sclr) begin
                r_t <= 1'b0;
            end else if (en && w_lower_ones) begin
                r_t <= ~r_t;
            end
        end

        assign w_q[i] = r_t;
    end

    assign count = w_q;

endmodule

// File: rtl/tff_counter_sequencer.sv
// -----------------------------------------------------------------------------
// tff_counter_sequencer
// Sequences a T-FF counter core through IDLE / RUN / PAUSE / DONE with a
// programmable prescaler and terminal count.
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   start from IDLE/DONE (re-latches config) or resume from PAUSE
//   stop      in   pause from RUN, or abort to IDLE from PAUSE/DONE
//   step      in   single increment, honoured only in IDLE
//   mode      in   0 = free-running wrap, 1 = one-shot
//   limit     in   terminal count (latched on start from IDLE/DONE)
//   prescale  in   tick every prescale+1 cycles (latched with limit)
//   count     out  counter value
//   state     out  FSM state encoding
//   busy      out  high in RUN or PAUSE
//   tc        out  one-cycle pulse on a free-mode wrap
//   done      out  one-cycle pulse on entry to DONE
// Command priority: stop > start > step.
// -----------------------------------------------------------------------------
module tff_counter_sequencer
    import tff_counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    input  logic [PRE_W-1:0] prescale,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    seq_state_e       r_state;
    seq_state_e       w_state_next;
    logic [PRE_W-1:0] r_pre_cnt;
    logic [PRE_W-1:0] w_pre_cnt_next;
    logic [WIDTH-1:0] r_limit;
    logic [WIDTH-1:0] w_limit_next;
    logic [PRE_W-1:0] r_prescale;
    logic [PRE_W-1:0] w_prescale_next;
    logic             r_mode;
    logic             w_mode_next;
    logic             r_tc;
    logic             w_tc_next;
    logic             r_done;
    logic             w_done_next;

    logic             w_core_en;
    logic             w_core_sclr;
    logic [WIDTH-1:0] w_count;
    logic             w_tick;
    logic             w_at_limit;

    tff_counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_core_en),
        .sclr  (w_core_sclr),
        .count (w_count)
    );

    assign w_tick     = (r_state == RUN) && (r_pre_cnt == r_prescale);
    assign w_at_limit = (w_count == r_limit);

    // ------------------------------------------------------------------
    // Next-state and core control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_pre_cnt_next  = r_pre_cnt;
        w_limit_next    = r_limit;
        w_prescale_next = r_prescale;
        w_mode_next     = r_mode;
        w_tc_next       = 1'b0;
        w_done_next     = 1'b0;
        w_core_en       = 1'b0;
        w_core_sclr     = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (stop) begin
                    // stop wins over start and step; nothing to abort in IDLE.
                end else if (start) begin
                    w_limit_next    = limit;
                    w_prescale_next = prescale;
                    w_mode_next     = mode;
                    w_pre_cnt_next  = '0;
                    w_core_sclr     = 1'b1;
                    w_state_next    = RUN;
                end else if (step) begin
                    // Manual stepping compares against the live limit input.
                    if (w_count == limit) begin
                        w_core_sclr = 1'b1;
                    end else begin
                        w_core_en = 1'b1;
                    end
                end
            end

            RUN: begin
                if (stop) begin
                    // Freeze count and prescaler phase; no tick at this edge.
                    w_state_next = PAUSE;
                end else if (w_tick) begin
                    w_pre_cnt_next = '0;
                    if (!w_at_limit) begin
                        w_core_en = 1'b1;
                    end else if (r_mode == MODE_ONESHOT) begin
                        w_done_next  = 1'b1;
                        w_state_next = DONE;
                    end else begin
                        w_core_sclr = 1'b1;
                        w_tc_next   = 1'b1;
                    end
                end else begin
                    w_pre_cnt_next = r_pre_cnt + 1'b1;
                end
            end

            PAUSE: begin
                if (stop) begin
                    w_core_sclr  = 1'b1;
                    w_state_next = IDLE;
                end else if (start) begin
                    w_state_next = RUN;
                end
            end

            DONE: begin
                if (stop) begin
                    w_core_sclr  = 1'b1;
                    w_state_next = IDLE;
                end else if (start) begin
                    w_limit_next    = limit;
                    w_prescale_next = prescale;
                    w_mode_next     = mode;
                    w_pre_cnt_next  = '0;
                    w_core_sclr     = 1'b1;
                    w_state_next    = RUN;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pre_cnt  <= '0;
            r_limit    <= '0;
            r_prescale <= '0;
            r_mode     <= MODE_FREE;
            r_tc       <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pre_cnt  <= w_pre_cnt_next;
            r_limit    <= w_limit_next;
            r_prescale <= w_prescale_next;
            r_mode     <= w_mode_next;
            r_tc       <= w_tc_next;
            r_done     <= w_done_next;
        end
    end

    assign count = w_count;
    assign state = r_state;
    assign busy  = state_is_busy(r_state);
    assign tc    = r_tc;
    assign done  = r_done;

endmodule

// File: doc/tff_counter_sequencer.md
# tff_counter_sequencer

Control block for the team's synchronous T-flip-flop counter. It owns an 8-bit T-FF counter core and sequences it through start / pause / resume / stop, a programmable prescaler and a programmable terminal count. It reports busy, wrap and completion status to the board-level wrapper (switches in, LEDs out).

## Interface
Parameters:
- WIDTH, 8, counter width in bits.
- PRE_W, 4, prescaler width in bits.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  level-sampled command: start or resume.
- stop  in  1  level-sampled command: pause, or abort to idle.
- step  in  1  single increment; honoured in IDLE only.
- mode  in  1  0 = FREE (wrap forever), 1 = ONESHOT (finish at limit).
- limit  in  WIDTH  terminal count; latched on a start from IDLE or DONE.
- prescale  in  PRE_W  tick every prescale+1 cycles; latched with limit.
- count  out  WIDTH  counter value.
- state  out  2  FSM state encoding.
- busy  out  1  high in RUN or PAUSE.
- tc  out  1  one-cycle pulse on the FREE-mode wrap edge.
- done  out  1  one-cycle pulse on entry to DONE.

## Operation
- Reset values: state = IDLE, count = 0, prescaler = 0, busy = 0, tc = 0, done = 0, limit_q = 0, prescale_q = 0, mode_q = 0.
- Command priority when signals coincide: stop > start > step.
- Tick: in RUN, tick = (pre_cnt == prescale_q). On a tick, pre_cnt returns to 0; otherwise it increments. pre_cnt holds in all other states.
- IDLE:
  - start: latch mode/limit/prescale, clear count and pre_cnt, go to RUN.
  - step (without start or stop): count <= (count == limit) ? 0 : count + 1, using the live limit input. Stay in IDLE.
- RUN, on each tick:
  - If count != limit_q: count + 1.
  - If count == limit_q and mode_q = FREE: count <= 0 and tc pulses.
  - If count == limit_q and mode_q = ONESHOT: count holds, go to DONE, done pulses.
  - stop: go to PAUSE, with count and pre_cnt frozen.
- PAUSE:
  - start: go to RUN with count and pre_cnt unchanged; no re-latch.
  - stop: go to IDLE and clear count.
- DONE:
  - count holds at limit_q.
  - start: re-latch, clear count, go to RUN.
  - stop: go to IDLE and clear count.
- step is ignored outside IDLE. Commands are level-sampled, so a start held high in RUN is a no-op.
- limit = 0:
  - FREE: count stays 0 and tc pulses on every tick.
  - ONESHOT: done on the first tick.
- Arithmetic is modulo 2^WIDTH. limit = all-ones gives a full-range counter.
- Reset asserted mid-run forces all reset values immediately, without waiting for a clock edge.

## Timing
- start sampled at edge E0 → state = RUN after E0.
- With prescale = 0: count = 1 after E1, and it increments every edge after that.
- With prescale = P: increments occur at E(P+1), E(2(P+1)), and so on.
- tc and done are registered and asserted in the same cycle that count shows the wrapped (0) or final (limit_q) value.
- stop sampled at edge E → count value after E equals the value before E. No tick is taken at that edge.
- Resume from PAUSE preserves prescaler phase: the remaining cycles to the next tick equal those remaining when paused.

## Structure
- Package tff_counter_seq_pkg holds:
  - State enum: IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3.
  - Mode constants: MODE_FREE = 0, MODE_ONESHOT = 1.
- Sub-module tff_counter_core (parameter WIDTH):
  - Generate loop of T flip-flops.
  - Bit i toggles when en is high and all lower bits are 1.
  - Synchronous clear input sclr; sclr has priority over en.
  - Uses the same async active-low rst_n.
- The sequencer drives en and sclr from the FSM and tick logic, and does its limit compare on the core's count.

## Test plan
- Reset: drive rst_n = 0 mid-RUN at count = 5 → count = 0, state = IDLE, busy = 0 before the next clk edge.
- FREE wrap: limit = 3, prescale = 0, start → count 1, 2, 3, 0, 1… on consecutive edges; tc high only in the cycles where count = 0 after a wrap.
- ONESHOT with prescale: limit = 4, prescale = 2, start → count advances every 3 cycles; after reaching 4, state = DONE with a single done pulse; count then holds at 4 for 20 cycles.
- Pause/resume: prescale = 3, stop mid-prescale period with count = 2 → count frozen for 10 cycles. Then start → next increment arrives after exactly the remaining prescale cycles. stop twice → IDLE with count = 0.
- Priority: start and stop high together in IDLE → stays IDLE. step in RUN → no effect. step ×3 in IDLE with limit = 1 → count 1, 0, 1.
- Corners:
  - limit = 0 in FREE → tc pulses on every tick.
  - limit = 255, prescale = 0 → full 0–255 sweep, then wrap to 0 with tc.
